// File: rtl/qsys_pio_pkg.sv
// Shared constants for the key-input PIO: register map and edge-type codes,
// plus the per-bit edge selection helper.
package qsys_pio_pkg;

   // Avalon word addresses
   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   // EDGE_TYPE encodings
   localparam int unsigned EDGE_RISE = 0;
   localparam int unsigned EDGE_FALL = 1;
   localparam int unsigned EDGE_ANY  = 2;

   // Returns 1 when the transition prv -> cur is one the block is configured to capture.
   function automatic logic edge_hit(input int unsigned edge_type, input logic cur,
                                     input logic prv);
      logic hit;
      hit = 1'b0;
      if (edge_type == EDGE_RISE) begin
         hit = cur & ~prv;
      end else if (edge_type == EDGE_FALL) begin
         hit = ~cur & prv;
      end else begin
         hit = cur ^ prv;
      end
      return hit;
   endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// Debounce filter for one synchronised key line: the stable level only follows
// the input after it has held a new value for DEBOUNCE_CYCLES clocks.
module pio_debounce_bit
   import qsys_pio_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter logic        IDLE            = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sync_in,
   output logic stable
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] cnt;

   // Count while the input disagrees with the accepted level; accept it on the last count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt    <= '0;
         stable <= IDLE;
      end else if (sync_in == stable) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt    <= '0;
         stable <= sync_in;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/qsys_pio_key_irq.sv
// Avalon-MM input PIO for key lines with per-bit edge capture and masked level IRQ.
// Optional per-line debounce is built when PIO_KEY_DEBOUNCE_EN is defined;
// otherwise the synchronised input is taken as stable every clock.
module qsys_pio_key_irq
   import qsys_pio_pkg::*;
#(
   parameter int unsigned      WIDTH           = 4,
   parameter int unsigned      EDGE_TYPE       = 1,
   parameter logic [WIDTH-1:0] IDLE_LEVEL      = {WIDTH{1'b1}},
   parameter int unsigned      DEBOUNCE_CYCLES = 1000000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] sync0;
   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_capture;
   logic [WIDTH-1:0] edge_hits;
   logic [WIDTH-1:0] edge_clr;
   logic [WIDTH-1:0] edge_capture_next;
   logic             mask_we;
   logic [31:0]      rd_next;

   if (WIDTH < 32) begin : g_wd_unused
      logic unused_writedata;
      assign unused_writedata = ^writedata[31:WIDTH];
   end

   // Two-flop synchroniser for the asynchronous key inputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync0 <= IDLE_LEVEL;
         sync1 <= IDLE_LEVEL;
      end else begin
         sync0 <= in_port;
         sync1 <= sync0;
      end
   end

`ifdef PIO_KEY_DEBOUNCE_EN
   for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
      pio_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .IDLE            (IDLE_LEVEL[i])
      ) u_debounce (
         .clk     (clk),
         .reset_n (reset_n),
         .sync_in (sync1[i]),
         .stable  (stable[i])
      );
   end
`else
   localparam int unsigned UNUSED_DEBOUNCE_CYCLES = DEBOUNCE_CYCLES;

   // Without debounce the synchronised level is accepted every clock.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable <= IDLE_LEVEL;
      end else begin
         stable <= sync1;
      end
   end
`endif

   // Edge selection and write-1-to-clear; a new edge in the same clock beats the clear.
   always_comb begin
      edge_hits = '0;
      for (int i = 0; i < WIDTH; i++) begin
         edge_hits[i] = edge_hit(EDGE_TYPE, stable[i], prev[i]);
      end
      edge_clr = '0;
      if (chipselect && !write_n && (address == ADDR_EDGE)) begin
         edge_clr = writedata[WIDTH-1:0];
      end
      edge_capture_next = (edge_capture & ~edge_clr) | edge_hits;
      mask_we = chipselect && !write_n && (address == ADDR_MASK);
   end

   // Read mux; evaluated every clock regardless of chipselect.
   always_comb begin
      rd_next = '0;
      case (address)
         ADDR_DATA: rd_next[WIDTH-1:0] = stable;
         ADDR_MASK: rd_next[WIDTH-1:0] = irq_mask;
         ADDR_EDGE: rd_next[WIDTH-1:0] = edge_capture;
         default:   rd_next = '0;
      endcase
   end

   // Edge history, host registers, registered read data and interrupt.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev         <= IDLE_LEVEL;
         irq_mask     <= '0;
         edge_capture <= '0;
         readdata     <= '0;
         irq          <= 1'b0;
      end else begin
         prev         <= stable;
         edge_capture <= edge_capture_next;
         readdata     <= rd_next;
         irq          <= |(edge_capture & irq_mask);
         if (mask_we) begin
            irq_mask <= writedata[WIDTH-1:0];
         end
      end
   end

endmodule

// File: tb/tb_qsys_pio_key_irq.sv
// Directed self-checking bench for qsys_pio_key_irq (WIDTH=4, falling edges).
// Build with PIO_KEY_DEBOUNCE_EN defined to also exercise the debounce path.
module tb_qsys_pio_key_irq;

`ifdef PIO_KEY_DEBOUNCE_EN
   localparam int DLY = 15;
`else
   localparam int DLY = 0;
`endif

   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port;
   logic [31:0] readdata;
   logic        irq;

   int n_cmp = 0;
   int n_bad = 0;

   qsys_pio_key_irq #(
      .WIDTH           (4),
      .EDGE_TYPE       (1),
      .IDLE_LEVEL      (4'hF),
      .DEBOUNCE_CYCLES (16)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic test_reset();
      repeat (2) tick();
      n_cmp++;
      if (readdata !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_readdata: got %h want %h", readdata, 32'h0);
      end
      n_cmp++;
      if (irq !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_irq: got %b want 0", irq);
      end
      reset_n = 1'b1;
      address = 2'd0;
      tick();
      n_cmp++;
      if (readdata !== 32'h0000000F) begin
         n_bad++;
         $display("FAIL reset_data_read: got %h want %h", readdata, 32'hF);
      end
      address = 2'd2;
      tick();
      n_cmp++;
      if (readdata !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_mask_read: got %h want %h", readdata, 32'h0);
      end
      address = 2'd3;
      tick();
      n_cmp++;
      if (readdata !== 32'h0 || irq !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_edge_read: got %h irq %b want 0 irq 0", readdata, irq);
      end
   endtask

   task automatic test_falling_edge();
      bus_write(2'd2, 32'h1);
      address = 2'd3;
      in_port = 4'hE;
      repeat (3 + DLY) tick();
      tick();
      n_cmp++;
      if (irq !== 1'b0 || readdata !== 32'h0) begin
         n_bad++;
         $display("FAIL fall_latency_early: irq %b rd %h want irq 0 rd 0", irq, readdata);
      end
      tick();
      n_cmp++;
      if (readdata !== 32'h1) begin
         n_bad++;
         $display("FAIL fall_capture: got %h want %h", readdata, 32'h1);
      end
      n_cmp++;
      if (irq !== 1'b1) begin
         n_bad++;
         $display("FAIL fall_irq: got %b want 1", irq);
      end
   endtask

   task automatic test_clear();
      bus_write(2'd3, 32'h1);
      n_cmp++;
      if (irq !== 1'b1) begin
         n_bad++;
         $display("FAIL clear_irq_held: got %b want 1", irq);
      end
      tick();
      n_cmp++;
      if (irq !== 1'b0 || readdata !== 32'h0) begin
         n_bad++;
         $display("FAIL clear_done: irq %b rd %h want irq 0 rd 0", irq, readdata);
      end
   endtask

   task automatic test_set_beats_clear();
      in_port = 4'hF;
      repeat (4 + DLY) tick();
      n_cmp++;
      if (readdata !== 32'h0) begin
         n_bad++;
         $display("FAIL rise_not_captured: got %h want %h", readdata, 32'h0);
      end
      in_port = 4'hE;
      repeat (3 + DLY) tick();
      bus_write(2'd3, 32'h1);
      tick();
      n_cmp++;
      if (readdata !== 32'h1) begin
         n_bad++;
         $display("FAIL set_beats_clear: got %h want %h", readdata, 32'h1);
      end
      bus_write(2'd3, 32'h1);
      tick();
      n_cmp++;
      if (readdata !== 32'h0 || irq !== 1'b0) begin
         n_bad++;
         $display("FAIL reclear: rd %h irq %b want rd 0 irq 0", readdata, irq);
      end
   endtask

   task automatic test_mask_gating();
      bus_write(2'd2, 32'h0);
      address = 2'd3;
      in_port = 4'hA;
      repeat (6 + DLY) tick();
      n_cmp++;
      if (readdata !== 32'h4 || irq !== 1'b0) begin
         n_bad++;
         $display("FAIL masked_edge: rd %h irq %b want rd 4 irq 0", readdata, irq);
      end
      bus_write(2'd2, 32'h4);
      n_cmp++;
      if (irq !== 1'b0) begin
         n_bad++;
         $display("FAIL mask_irq_early: got %b want 0", irq);
      end
      tick();
      n_cmp++;
      if (irq !== 1'b1) begin
         n_bad++;
         $display("FAIL mask_irq: got %b want 1", irq);
      end
      address = 2'd2;
      tick();
      n_cmp++;
      if (readdata !== 32'h4) begin
         n_bad++;
         $display("FAIL mask_read: got %h want %h", readdata, 32'h4);
      end
      address = 2'd0;
      tick();
      n_cmp++;
      if (readdata !== 32'hA) begin
         n_bad++;
         $display("FAIL data_read: got %h want %h", readdata, 32'hA);
      end
      address = 2'd1;
      tick();
      n_cmp++;
      if (readdata !== 32'h0) begin
         n_bad++;
         $display("FAIL addr1_read: got %h want %h", readdata, 32'h0);
      end
      bus_write(2'd0, 32'hFFFF_FFF5);
      bus_write(2'd1, 32'hFFFF_FFFF);
      address = 2'd0;
      tick();
      n_cmp++;
      if (readdata !== 32'hA) begin
         n_bad++;
         $display("FAIL data_write_ignored: got %h want %h", readdata, 32'hA);
      end
      address = 2'd2;
      tick();
      n_cmp++;
      if (readdata !== 32'h4) begin
         n_bad++;
         $display("FAIL addr1_write_ignored: got %h want %h", readdata, 32'h4);
      end
   endtask

   task automatic test_rise_ignored();
      bus_write(2'd3, 32'hF);
      in_port = 4'hF;
      address = 2'd3;
      repeat (6 + DLY) tick();
      n_cmp++;
      if (readdata !== 32'h0 || irq !== 1'b0) begin
         n_bad++;
         $display("FAIL rise_ignored: rd %h irq %b want rd 0 irq 0", readdata, irq);
      end
   endtask

   task automatic test_reset_mid();
      bus_write(2'd2, 32'hF);
      in_port = 4'h7;
      repeat (10) tick();
      #2;
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (readdata !== 32'h0 || irq !== 1'b0) begin
         n_bad++;
         $display("FAIL async_reset: rd %h irq %b want rd 0 irq 0", readdata, irq);
      end
      in_port = 4'hF;
      tick();
      reset_n = 1'b1;
      address = 2'd3;
      repeat (8 + DLY) tick();
      n_cmp++;
      if (readdata !== 32'h0 || irq !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_no_edge: rd %h irq %b want rd 0 irq 0", readdata, irq);
      end
      address = 2'd2;
      tick();
      n_cmp++;
      if (readdata !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_mask_cleared: got %h want %h", readdata, 32'h0);
      end
      address = 2'd0;
      tick();
      n_cmp++;
      if (readdata !== 32'hF) begin
         n_bad++;
         $display("FAIL reset_idle_level: got %h want %h", readdata, 32'hF);
      end
   endtask

`ifdef PIO_KEY_DEBOUNCE_EN
   task automatic test_debounce();
      address = 2'd0;
      in_port = 4'hD;
      repeat (10) tick();
      in_port = 4'hF;
      repeat (25) tick();
      n_cmp++;
      if (readdata !== 32'hF) begin
         n_bad++;
         $display("FAIL glitch_data: got %h want %h", readdata, 32'hF);
      end
      address = 2'd3;
      tick();
      n_cmp++;
      if (readdata !== 32'h0) begin
         n_bad++;
         $display("FAIL glitch_edge: got %h want %h", readdata, 32'h0);
      end
      address = 2'd0;
      in_port = 4'hD;
      repeat (17) tick();
      n_cmp++;
      if (readdata !== 32'hF) begin
         n_bad++;
         $display("FAIL debounce_early: got %h want %h", readdata, 32'hF);
      end
      repeat (3) tick();
      n_cmp++;
      if (readdata !== 32'hD) begin
         n_bad++;
         $display("FAIL debounce_stable: got %h want %h", readdata, 32'hD);
      end
      address = 2'd3;
      tick();
      n_cmp++;
      if (readdata !== 32'h2) begin
         n_bad++;
         $display("FAIL debounce_edge: got %h want %h", readdata, 32'h2);
      end
   endtask
`endif

   initial begin
      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = 4'hF;
      test_reset();
      test_falling_edge();
      test_clear();
      test_set_beats_clear();
      test_mask_gating();
      test_rise_ignored();
      test_reset_mid();
`ifdef PIO_KEY_DEBOUNCE_EN
      test_debounce();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
